// File: rtl/instruction_decoder.sv
// instruction_decoder: latches the fetched instruction on phase 1 of the
// 4-phase instruction period, decodes it into held field outputs plus
// one-cycle execute strobes, and owns the zero flag used by JNZ.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   pc_count[1:0]       phase from program_sequencer (0,1,2,3,...)
//   pm_data[7:0]        program ROM data, sampled on the phase-1 edge
//   alu_zero            ALU result-is-zero, sampled on the phase-2 edge
//   ir[7:0]             instruction register
//   jump, conditional_jump, jump_addr[3:0], dont_jump_flag
//                       jump interface back to the sequencer
//   reg_we, alu_en      execute strobes, high only while pc_count==2
//   imm_sel, dst_sel[1:0], src_sel[1:0], alu_func[2:0], imm[3:0]
//                       datapath control fields, held per instruction
module instruction_decoder #(
  parameter logic [7:0] RESET_IR = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pc_count,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic [7:0] ir,
  output logic       jump,
  output logic       conditional_jump,
  output logic [3:0] jump_addr,
  output logic       dont_jump_flag,
  output logic       reg_we,
  output logic       alu_en,
  output logic       imm_sel,
  output logic [1:0] dst_sel,
  output logic [1:0] src_sel,
  output logic [2:0] alu_func,
  output logic [3:0] imm
);

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned NIB_W  = 4;

  localparam logic [1:0] PH_FETCH = 2'd1;
  localparam logic [1:0] PH_RUN   = 2'd2;

  // Major opcode in pm_data[7:6]; jump-class sub-opcode in pm_data[5:4].
  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;
  localparam logic [1:0] SUB_JMP = 2'b00;
  localparam logic [1:0] SUB_JNZ = 2'b01;

  // Fields that hold for the whole instruction period.
  typedef struct packed {
    logic              imm_sel;
    logic [SEL_W-1:0]  dst_sel;
    logic [SEL_W-1:0]  src_sel;
    logic [FUNC_W-1:0] alu_func;
    logic [NIB_W-1:0]  imm;
    logic              jump;
    logic              conditional_jump;
    logic [NIB_W-1:0]  jump_addr;
  } fields_t;

  fields_t    dec_c;
  logic       dec_reg_we_c;
  logic       dec_alu_en_c;
  fields_t    fields_q;
  logic [7:0] ir_q;
  logic       reg_we_q;
  logic       alu_en_q;
  logic       zero_flag_q;

  logic fetch_c;
  logic run_c;

  assign fetch_c = (pc_count == PH_FETCH);
  assign run_c   = (pc_count == PH_RUN);

  // Instruction decode of the word on the ROM bus; unused fields stay 0.
  always_comb begin
    dec_c        = '0;
    dec_reg_we_c = 1'b0;
    dec_alu_en_c = 1'b0;
    case (pm_data[7:6])
      OP_LDI: begin
        dec_reg_we_c  = 1'b1;
        dec_c.imm_sel = 1'b1;
        dec_c.dst_sel = pm_data[5:4];
        dec_c.imm     = pm_data[3:0];
      end
      OP_MOV: begin
        dec_reg_we_c  = 1'b1;
        dec_c.dst_sel = pm_data[5:4];
        dec_c.src_sel = pm_data[3:2];
      end
      OP_ALU: begin
        dec_reg_we_c   = 1'b1;
        dec_alu_en_c   = 1'b1;
        dec_c.alu_func = pm_data[5:3];
        dec_c.src_sel  = pm_data[2:1];
      end
      OP_JMP: begin
        // 11 10 and the reserved 11 11 fall through as NOP.
        case (pm_data[5:4])
          SUB_JMP: begin
            dec_c.jump      = 1'b1;
            dec_c.jump_addr = pm_data[3:0];
          end
          SUB_JNZ: begin
            dec_c.conditional_jump = 1'b1;
            dec_c.jump_addr        = pm_data[3:0];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Instruction register and held fields load only on the phase-1 edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q     <= RESET_IR;
      fields_q <= '0;
    end else if (fetch_c) begin
      ir_q     <= pm_data;
      fields_q <= dec_c;
    end
  end

  // Strobes set on the phase-1 edge and clear on the next edge, so they
  // are high exactly during the pc_count==2 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_we_q <= 1'b0;
      alu_en_q <= 1'b0;
    end else begin
      reg_we_q <= fetch_c & dec_reg_we_c;
      alu_en_q <= fetch_c & dec_alu_en_c;
    end
  end

  // Zero flag captures the ALU result at the end of the execute cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_flag_q <= 1'b0;
    end else if (run_c && alu_en_q) begin
      zero_flag_q <= alu_zero;
    end
  end

  assign ir               = ir_q;
  assign reg_we           = reg_we_q;
  assign alu_en           = alu_en_q;
  assign dont_jump_flag   = zero_flag_q;
  assign imm_sel          = fields_q.imm_sel;
  assign dst_sel          = fields_q.dst_sel;
  assign src_sel          = fields_q.src_sel;
  assign alu_func         = fields_q.alu_func;
  assign imm              = fields_q.imm;
  assign jump             = fields_q.jump;
  assign conditional_jump = fields_q.conditional_jump;
  assign jump_addr        = fields_q.jump_addr;

endmodule
